// File: rtl/pc_ctrl_pkg.sv
// Shared constants and types for the PC redirect control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: opcode field values, branch condition codes, control FSM
// state type and bit positions of the {N,Z,C,V} flag vector.
`timescale 1ns/1ps
package pc_ctrl_pkg;

  // Opcode field values (Bcc uses instr[15:12], JMP/HLT use instr[15:11])
  localparam logic [3:0] OP_BCC = 4'hC;
  localparam logic [4:0] OP_JMP = 5'b11101;
  localparam logic [4:0] OP_HLT = 5'b11111;

  // Branch condition codes carried in instr[11:8]
  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_GE = 4'd9;
  localparam logic [3:0] COND_LT = 4'd10;
  localparam logic [3:0] COND_GT = 4'd11;
  localparam logic [3:0] COND_LE = 4'd12;
  localparam logic [3:0] COND_NV = 4'd13;  // 13..15 all mean "never"

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: condition code + {N,Z,C,V} -> taken.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: cond[3:0] condition code, flags[3:0] {N,Z,C,V}, taken result.
`timescale 1ns/1ps
module cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[FLG_N];
  assign z = flags[FLG_Z];
  assign c = flags[FLG_C];
  assign v = flags[FLG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      default: taken = 1'b0;  // NV encodings
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// PC redirect control: decodes Bcc/JMP/HLT, owns the flag register, RUN/HALT FSM.
// Latency: BRANCH/JMP/pc_hold combinational from instr, flags and state (zero cycles).
// Backpressure: none; HALT freezes the PC via pc_hold until a resume pulse.
//
// Ports: clk, clr (async active-high); instr; alu_flags/flag_we flag update;
// resume leaves HALT; disp8/label11 raw immediates; BRANCH/JMP redirects;
// pc_hold gates PC/regfile/memory writes; halted; flags {N,Z,C,V}.
// Optional: define BRANCH_CTRL_STATS_EN to add saturating taken_cnt/jmp_cnt.
`timescale 1ns/1ps
module branch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int IW = 16
`ifdef BRANCH_CTRL_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [IW-1:0] instr,
  input  logic [3:0]    alu_flags,
  input  logic          flag_we,
  input  logic          resume,
  output logic [7:0]    disp8,
  output logic [10:0]   label11,
  output logic          BRANCH,
  output logic          JMP,
  output logic          pc_hold,
  output logic          halted,
  output logic [3:0]    flags
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] jmp_cnt
`endif
);

  state_t state, state_nxt;
  logic   is_bcc, is_jmp, is_hlt, cond_true;

  // Immediates are passed through unconditionally; BRANCH/JMP qualify them.
  assign disp8   = instr[7:0];
  assign label11 = instr[10:0];

  assign is_bcc = (instr[15:12] == OP_BCC);
  assign is_jmp = (instr[15:11] == OP_JMP);
  assign is_hlt = (instr[15:11] == OP_HLT);

  // Registered flags only: a compare and a dependent branch in the same
  // cycle see the old flags.
  cond_eval u_cond_eval (
    .cond  (instr[11:8]),
    .flags (flags),
    .taken (cond_true)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BRANCH    = 1'b0;
    JMP       = 1'b0;
    pc_hold   = 1'b0;
    case (state)
      ST_RUN: begin
        BRANCH = is_bcc & cond_true;
        JMP    = is_jmp;
        // Hold in the HLT cycle itself so the PC parks on the HLT address.
        if (is_hlt) begin
          pc_hold   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // Release in the resume cycle so the PC steps past the HLT without
        // decoding it again.
        pc_hold = ~resume;
        if (resume) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign halted = (state == ST_HALT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                             flags <= 4'b0000;
    else if (state == ST_RUN && flag_we) flags <= alu_flags;
  end

`ifdef BRANCH_CTRL_STATS_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      taken_cnt <= '0;
      jmp_cnt   <= '0;
    end else begin
      if (BRANCH && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      if (JMP && jmp_cnt != '1)      jmp_cnt   <= jmp_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl against a behavioural reference model.
// Latency: checks combinational outputs mid-cycle, registered state after each edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] instr;
  logic [3:0]  alu_flags;
  logic        flag_we;
  logic        resume;
  logic [7:0]  disp8;
  logic [10:0] label11;
  logic        BRANCH, JMP, pc_hold, halted;
  logic [3:0]  flags;
`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] taken_cnt, jmp_cnt;
`endif

  branch_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .instr     (instr),
    .alu_flags (alu_flags),
    .flag_we   (flag_we),
    .resume    (resume),
    .disp8     (disp8),
    .label11   (label11),
    .BRANCH    (BRANCH),
    .JMP       (JMP),
    .pc_hold   (pc_hold),
    .halted    (halted),
    .flags     (flags)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .taken_cnt (taken_cnt),
    .jmp_cnt   (jmp_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  bit       m_halt;
  bit [3:0] m_flags;
  int       m_taken, m_jmps;

  // Condition truth taken straight from the condition-code table.
  function automatic bit ref_cond(input int c, input bit [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      0:  return 1'b1;
      1:  return z;
      2:  return !z;
      3:  return cf;
      4:  return !cf;
      5:  return n;
      6:  return !n;
      7:  return v;
      8:  return !v;
      9:  return n == v;
      10: return n != v;
      11: return !z && (n == v);
      12: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: drive, check mid-cycle, advance model across the edge.
  // Entered and left at 1 ns after a rising edge.
  task automatic cyc(input logic [15:0] ins, input logic we, input logic [3:0] af, input logic res);
    bit is_bcc, is_jmp, is_hlt, e_br, e_jmp, e_hold, n_halt;
    bit [3:0] n_flags;
    instr = ins; flag_we = we; alu_flags = af; resume = res;
    is_bcc = (ins[15:12] == 4'hC);
    is_jmp = (ins[15:11] == 5'd29);
    is_hlt = (ins[15:11] == 5'd31);
    e_br   = !m_halt && is_bcc && ref_cond(int'(ins[11:8]), m_flags);
    e_jmp  = !m_halt && is_jmp;
    e_hold = m_halt ? !res : is_hlt;
    #3;
    chk("BRANCH", 16'(BRANCH), 16'(e_br));
    chk("JMP", 16'(JMP), 16'(e_jmp));
    chk("pc_hold", 16'(pc_hold), 16'(e_hold));
    chk("disp8", 16'(disp8), 16'(ins[7:0]));
    chk("label11", 16'(label11), 16'(ins[10:0]));
    n_flags = m_flags;
    n_halt  = m_halt;
    if (!m_halt) begin
      if (we) n_flags = af;
      if (is_hlt) n_halt = 1'b1;
    end else if (res) n_halt = 1'b0;
    if (e_br && m_taken < 65535) m_taken++;
    if (e_jmp && m_jmps < 65535) m_jmps++;
    @(posedge clk); #1;
    m_flags = n_flags;
    m_halt  = n_halt;
    chk("flags", 16'(flags), 16'(m_flags));
    chk("halted", 16'(halted), 16'(m_halt));
`ifdef BRANCH_CTRL_STATS_EN
    chk("taken_cnt", taken_cnt, 16'(m_taken));
    chk("jmp_cnt", jmp_cnt, 16'(m_jmps));
`endif
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2:    r[15:12] = 4'hC;
      3, 4:       r[15:11] = 5'd29;
      5:          r[15:11] = 5'd31;
      default:    if (r[15:12] == 4'hC || r[15:11] == 5'd29 || r[15:11] == 5'd31) r[15] = 1'b0;
    endcase
    return r;
  endfunction

  initial begin
    instr = 16'h0000; flag_we = 1'b0; alu_flags = 4'h0; resume = 1'b0;
    m_halt = 1'b0; m_flags = 4'h0; m_taken = 0; m_jmps = 0;

    // Reset
    clr = 1'b1;
    #10 clr = 1'b0;
    @(posedge clk); #1;
    chk("rst_flags", 16'(flags), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_hold", 16'(pc_hold), 16'h0);
    chk("rst_branch", 16'(BRANCH), 16'h0);
    chk("rst_jmp", 16'(JMP), 16'h0);
    repeat (3) cyc(16'h0000, 1'b0, 4'h0, 1'b0);

    // Same-cycle hazard: branch sees old flags, then new ones
    cyc(16'hC105, 1'b1, 4'b0100, 1'b0);
    cyc(16'hC105, 1'b0, 4'b0000, 1'b0);
    // BEQ +10 with Z set, then clear Z and retry
    cyc(16'hC10A, 1'b1, 4'b0000, 1'b0);
    cyc(16'hC10A, 1'b0, 4'b0000, 1'b0);
    // JMP 15
    cyc(16'hE80F, 1'b0, 4'b0000, 1'b0);
    // A few taken branches to exercise counters
    cyc(16'hC0F0, 1'b1, 4'b0100, 1'b0);
    repeat (3) cyc(16'hC10A, 1'b0, 4'h0, 1'b0);
    cyc(16'hE801, 1'b0, 4'h0, 1'b0);

    // HLT: held 5 cycles with flag_we ignored, then resume
    cyc(16'hF800, 1'b0, 4'h0, 1'b0);
    repeat (5) cyc(16'hF800, 1'b1, 4'hF, 1'b0);
    cyc(16'hF800, 1'b1, 4'hA, 1'b1);
    cyc(16'h0000, 1'b1, 4'h9, 1'b0);

    // Asynchronous reset in the middle of HALT
    cyc(16'hF800, 1'b0, 4'h0, 1'b0);
    cyc(16'hC0AA, 1'b0, 4'h0, 1'b0);
    #2 clr = 1'b1;
    #1;
    chk("async_halted", 16'(halted), 16'h0);
    chk("async_flags", 16'(flags), 16'h0);
    m_halt = 1'b0; m_flags = 4'h0; m_taken = 0; m_jmps = 0;
    @(posedge clk); #2 clr = 1'b0;
    @(posedge clk); #1;

`ifdef BRANCH_CTRL_STATS_EN
    // Saturation of the taken counter
    cyc(16'h0000, 1'b1, 4'b0100, 1'b0);
    force dut.taken_cnt = 16'hFFFF;
    #1 release dut.taken_cnt;
    m_taken = 65535;
    #1 cyc(16'hC10A, 1'b0, 4'h0, 1'b0);
    chk("taken_sat", taken_cnt, 16'hFFFF);
`endif

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      cyc(rand_instr(), 1'($urandom_range(0, 1)), 4'($urandom),
          ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
